// File: rtl/fm_demodulator_if.sv
// rtl/fm_demodulator_if.sv - sample stream bundle between the AGC output and the FM discriminator
interface fm_demodulator_if;
  logic               clk_enable;
  logic signed [38:0] inp_I;
  logic signed [38:0] inp_Q;
  logic        [12:0] out_fm;

  modport master (
    output clk_enable,
    output inp_I,
    output inp_Q,
    input  out_fm
  );

  modport slave (
    input  clk_enable,
    input  inp_I,
    input  inp_Q,
    output out_fm
  );
endinterface

// File: rtl/fm_demodulator.sv
// rtl/fm_demodulator.sv - cross-product FM discriminator, I/Q sfix39_En36 in, ufix13_En12 offset-binary out
module fm_demodulator #(
  parameter int OUT_OFFSET = 4096
) (
  input  logic              clk,
  input  logic              reset,
  fm_demodulator_if.slave   fm_if
);

  logic signed [38:0] i_prev_q, i_prev_d;
  logic signed [38:0] q_prev_q, q_prev_d;
  logic signed [77:0] pa_q, pa_d;
  logic signed [77:0] pb_q, pb_d;
  logic        [12:0] out_q, out_d;

  logic signed [78:0] diff_w;
  logic signed [78:0] shift_w;
  logic signed [78:0] sum_w;

  // Full-precision products; the 78-bit targets keep every bit of 39x39 signed.
  assign pa_d     = i_prev_q * fm_if.inp_Q;
  assign pb_d     = q_prev_q * fm_if.inp_I;
  assign i_prev_d = fm_if.inp_I;
  assign q_prev_d = fm_if.inp_Q;

  // Arithmetic shift floors toward -inf, converting En72 to En12 without rounding.
  assign diff_w  = 79'(pa_q) - 79'(pb_q);
  assign shift_w = diff_w >>> 60;
  assign sum_w   = shift_w + 79'(OUT_OFFSET);

  always_comb begin
    out_d = sum_w[12:0];
    if (sum_w < 0) begin
      out_d = 13'd0;
    end else if (sum_w > 79'sd8191) begin
      out_d = 13'h1fff;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_prev_q <= '0;
      q_prev_q <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      out_q    <= '0;
    end else if (fm_if.clk_enable) begin
      i_prev_q <= i_prev_d;
      q_prev_q <= q_prev_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      out_q    <= out_d;
    end
  end

  assign fm_if.out_fm = out_q;

endmodule

// File: tb/tb_fm_demodulator.sv
// tb/tb_fm_demodulator.sv - randomized bench for fm_demodulator against an arithmetic reference model
module tb_fm_demodulator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fm_demodulator_if ifc ();

  fm_demodulator dut (
    .clk   (clk),
    .reset (reset),
    .fm_if (ifc)
  );

  always #5 clk = ~clk;

  localparam logic signed [38:0] ONE  = 39'sd68719476736;  // 1.0 in En36
  localparam logic signed [38:0] HALF = 39'sd34359738368;  // 0.5 in En36

  // Samples accepted since the last reset, preceded by two zero samples of history.
  logic signed [38:0] hist_i[$];
  logic signed [38:0] hist_q[$];
  logic        [12:0] model_out;

  task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ref_out(input logic signed [38:0] ai, input logic signed [38:0] aq,
                                          input logic signed [38:0] bi, input logic signed [38:0] bq);
    logic signed [127:0] ai_w, aq_w, bi_w, bq_w, d, t, s;
    logic signed [127:0] scale;
    scale = 128'sh1000000000000000;
    ai_w = ai; aq_w = aq; bi_w = bi; bq_w = bq;
    d = ai_w * bq_w - aq_w * bi_w;
    t = d / scale;
    if (d < 0 && (t * scale != d)) t = t - 1;
    s = t + 128'sd4096;
    if (s < 0) return 13'd0;
    if (s > 128'sd8191) return 13'd8191;
    return s[12:0];
  endfunction

  task automatic model_reset();
    hist_i = {39'sd0, 39'sd0};
    hist_q = {39'sd0, 39'sd0};
    model_out = 13'd0;
  endtask

  task automatic step(input logic en, input logic signed [38:0] vi, input logic signed [38:0] vq);
    int n;
    @(negedge clk);
    ifc.clk_enable = en;
    ifc.inp_I = vi;
    ifc.inp_Q = vq;
    @(posedge clk);
    #1;
    if (en) begin
      n = hist_i.size();
      model_out = ref_out(hist_i[n-2], hist_q[n-2], hist_i[n-1], hist_q[n-1]);
      hist_i.push_back(vi);
      hist_q.push_back(vq);
      if (hist_i.size() > 4) begin
        void'(hist_i.pop_front());
        void'(hist_q.pop_front());
      end
      check_val("pipe", ifc.out_fm, model_out);
    end else begin
      check_val("hold", ifc.out_fm, model_out);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ifc.clk_enable = 1'b0;
    #2;
    check_val("reset_async", ifc.out_fm, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pair_test(input string tag, input logic signed [38:0] i0, input logic signed [38:0] q0,
                           input logic signed [38:0] i1, input logic signed [38:0] q1, input logic [12:0] exp);
    do_reset();
    step(1'b1, i0, q0);
    check_val({tag, "_first"}, ifc.out_fm, 13'd4096);
    step(1'b1, i1, q1);
    step(1'b1, 39'sd0, 39'sd0);
    check_val(tag, ifc.out_fm, exp);
  endtask

  function automatic logic signed [38:0] rand_sample();
    logic [63:0] raw;
    logic signed [38:0] v;
    raw = {$urandom(), $urandom()};
    v = raw[38:0];
    return v >>> $urandom_range(14, 0);
  endfunction

  initial begin
    ifc.clk_enable = 1'b0;
    ifc.inp_I = '0;
    ifc.inp_Q = '0;
    model_reset();
    #12;
    check_val("reset_state", ifc.out_fm, 13'd0);
    @(negedge clk);
    reset = 1'b0;

    pair_test("quarter_turn", ONE, 39'sd0, 39'sd0, ONE, 13'h1fff);
    pair_test("mid_value", HALF, 39'sd0, HALF, HALF, 13'd5120);
    pair_test("reverse_turn", 39'sd0, ONE, ONE, 39'sd0, 13'd0);

    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, ONE, 39'sd0);
    check_val("constant", ifc.out_fm, 13'd4096);

    // Stall of five cycles mid-stream, then resume.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, rand_sample(), rand_sample());
    for (int k = 0; k < 5; k++) step(1'b0, rand_sample(), rand_sample());
    for (int k = 0; k < 4; k++) step(1'b1, rand_sample(), rand_sample());

    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(999, 0) == 0) do_reset();
      step($urandom_range(9, 0) < 8, rand_sample(), rand_sample());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
